mc_ctrl_fsm: RTL and testbench

- Multi-cycle MIPS-subset control unit for the project3 datapath.
- Sits directly upstream of the datapath's 32-bit clock-enabled registers (PC, IR, MDR, A, B, ALUOut) and drives their CE inputs, plus register-file, memory and mux selects.
- Sequences fetch/decode/execute/memory/writeback per instruction and stalls on a memory ready handshake.

---
 rtl/mc_ctrl_pkg.sv | 63 ++++++
 rtl/mc_ctrl_fsm_if.sv | 42 ++++
 rtl/mc_ctrl_alu_dec.sv | 24 ++
 rtl/mc_ctrl_fsm.sv | 188 ++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control unit: states, opcodes, functs and select codes.
// Optional instruction counter is enabled by defining MC_CTRL_PERF_CNT_EN.
package mc_ctrl_pkg;

    typedef logic [5:0] opcode_t;
    typedef logic [5:0] funct_t;
    typedef logic [2:0] alu_ctrl_t;
    typedef logic [1:0] src_b_t;
    typedef logic [1:0] pc_src_t;

    typedef enum logic [3:0] {
        S_IF,
        S_ID,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WR,
        S_WB_MEM,
        S_EX_R,
        S_WB_R,
        S_EX_I,
        S_WB_I,
        S_BR,
        S_JMP
    } state_t;

    localparam opcode_t OP_RTYPE = 6'b000000;
    localparam opcode_t OP_LW    = 6'b100011;
    localparam opcode_t OP_SW    = 6'b101011;
    localparam opcode_t OP_ADDI  = 6'b001000;
    localparam opcode_t OP_BEQ   = 6'b000100;
    localparam opcode_t OP_J     = 6'b000010;

    localparam funct_t FN_ADD = 6'b100000;
    localparam funct_t FN_SUB = 6'b100010;
    localparam funct_t FN_AND = 6'b100100;
    localparam funct_t FN_OR  = 6'b100101;
    localparam funct_t FN_SLT = 6'b101010;

    localparam alu_ctrl_t ALU_AND = 3'b000;
    localparam alu_ctrl_t ALU_OR  = 3'b001;
    localparam alu_ctrl_t ALU_ADD = 3'b010;
    localparam alu_ctrl_t ALU_SUB = 3'b110;
    localparam alu_ctrl_t ALU_SLT = 3'b111;

    localparam src_b_t SRCB_B      = 2'b00;
    localparam src_b_t SRCB_INC    = 2'b01;
    localparam src_b_t SRCB_IMM    = 2'b10;
    localparam src_b_t SRCB_IMM_SH = 2'b11;

    localparam pc_src_t PCSRC_ALU    = 2'b00;
    localparam pc_src_t PCSRC_ALUOUT = 2'b01;
    localparam pc_src_t PCSRC_JUMP   = 2'b10;

    // Byte step the datapath applies to PC when alu_src_b selects SRCB_INC.
    localparam int PC_INC = 4;

    // States whose exit to IF retires an instruction (MEM_WR only once memory is ready).
    function automatic logic is_completing(input state_t s);
        return (s == S_WB_R) || (s == S_WB_I) || (s == S_WB_MEM) ||
               (s == S_MEM_WR) || (s == S_BR) || (s == S_JMP);
    endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Control/status bundle between the control FSM (master) and the project3 datapath (slave).
// Unaffected by MC_CTRL_PERF_CNT_EN.
interface mc_ctrl_fsm_if;
    import mc_ctrl_pkg::*;

    opcode_t   opcode;
    funct_t    funct;
    logic      zero;
    logic      mem_ready;

    logic      pc_ce;
    logic      ir_ce;
    logic      mdr_ce;
    logic      ab_ce;
    logic      alu_out_ce;
    logic      reg_we;
    logic      mem_rd;
    logic      mem_we;
    logic      i_or_d;
    logic      alu_src_a;
    src_b_t    alu_src_b;
    alu_ctrl_t alu_ctrl;
    pc_src_t   pc_src;
    logic      reg_dst;
    logic      mem_to_reg;
    logic      illegal;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output pc_ce, ir_ce, mdr_ce, ab_ce, alu_out_ce, reg_we, mem_rd, mem_we,
               i_or_d, alu_src_a, alu_src_b, alu_ctrl, pc_src, reg_dst,
               mem_to_reg, illegal
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  pc_ce, ir_ce, mdr_ce, ab_ce, alu_out_ce, reg_we, mem_rd, mem_we,
               i_or_d, alu_src_a, alu_src_b, alu_ctrl, pc_src, reg_dst,
               mem_to_reg, illegal
    );

endinterface

// File: rtl/mc_ctrl_alu_dec.sv
// R-type funct to ALU control decoder with a valid flag for unsupported functs.
// Unaffected by MC_CTRL_PERF_CNT_EN.
module mc_ctrl_alu_dec
    import mc_ctrl_pkg::*;
(
    input  funct_t    i_funct,
    output alu_ctrl_t o_alu_ctrl,
    output logic      o_valid
);

    always_comb begin
        o_alu_ctrl = ALU_AND;
        o_valid    = 1'b1;
        case (i_funct)
            FN_ADD:  o_alu_ctrl = ALU_ADD;
            FN_SUB:  o_alu_ctrl = ALU_SUB;
            FN_AND:  o_alu_ctrl = ALU_AND;
            FN_OR:   o_alu_ctrl = ALU_OR;
            FN_SLT:  o_alu_ctrl = ALU_SLT;
            default: o_valid    = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS-subset control FSM driving datapath register CEs, memory requests and mux selects.
// Define MC_CTRL_PERF_CNT_EN to add the retired-instruction counter output instr_cnt.
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
`ifdef MC_CTRL_PERF_CNT_EN
    output logic [31:0] instr_cnt,
`endif
    mc_ctrl_fsm_if.master ctrl
);

    state_t    r_state;
    state_t    w_next_state;
    alu_ctrl_t w_alu_ctrl;
    logic      w_funct_ok;

    mc_ctrl_alu_dec u_alu_dec (
        .i_funct    (ctrl.funct),
        .o_alu_ctrl (w_alu_ctrl),
        .o_valid    (w_funct_ok)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IF;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Selects not used by a state rest at zero; reset overrides everything at the end.
    always_comb begin
        w_next_state    = r_state;
        ctrl.pc_ce      = 1'b0;
        ctrl.ir_ce      = 1'b0;
        ctrl.mdr_ce     = 1'b0;
        ctrl.ab_ce      = 1'b0;
        ctrl.alu_out_ce = 1'b0;
        ctrl.reg_we     = 1'b0;
        ctrl.mem_rd     = 1'b0;
        ctrl.mem_we     = 1'b0;
        ctrl.i_or_d     = 1'b0;
        ctrl.alu_src_a  = 1'b0;
        ctrl.alu_src_b  = SRCB_B;
        ctrl.alu_ctrl   = ALU_AND;
        ctrl.pc_src     = PCSRC_ALU;
        ctrl.reg_dst    = 1'b0;
        ctrl.mem_to_reg = 1'b0;
        ctrl.illegal    = 1'b0;

        case (r_state)
            S_IF: begin
                ctrl.mem_rd    = 1'b1;
                ctrl.alu_src_b = SRCB_INC;
                ctrl.alu_ctrl  = ALU_ADD;
                if (ctrl.mem_ready) begin
                    ctrl.ir_ce   = 1'b1;
                    ctrl.pc_ce   = 1'b1;
                    w_next_state = S_ID;
                end
            end
            S_ID: begin
                ctrl.ab_ce      = 1'b1;
                ctrl.alu_out_ce = 1'b1;
                ctrl.alu_src_b  = SRCB_IMM_SH;
                ctrl.alu_ctrl   = ALU_ADD;
                case (ctrl.opcode)
                    OP_RTYPE:     w_next_state = S_EX_R;
                    OP_LW, OP_SW: w_next_state = S_MEM_ADDR;
                    OP_ADDI:      w_next_state = S_EX_I;
                    OP_BEQ:       w_next_state = S_BR;
                    OP_J:         w_next_state = S_JMP;
                    default: begin
                        ctrl.illegal = 1'b1;
                        w_next_state = S_IF;
                    end
                endcase
            end
            S_EX_R: begin
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_out_ce = 1'b1;
                ctrl.alu_ctrl   = w_alu_ctrl;
                if (w_funct_ok) begin
                    w_next_state = S_WB_R;
                end else begin
                    ctrl.illegal = 1'b1;
                    w_next_state = S_IF;
                end
            end
            S_WB_R: begin
                ctrl.reg_we  = 1'b1;
                ctrl.reg_dst = 1'b1;
                w_next_state = S_IF;
            end
            S_EX_I: begin
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_src_b  = SRCB_IMM;
                ctrl.alu_ctrl   = ALU_ADD;
                ctrl.alu_out_ce = 1'b1;
                w_next_state    = S_WB_I;
            end
            S_WB_I: begin
                ctrl.reg_we  = 1'b1;
                w_next_state = S_IF;
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_src_b  = SRCB_IMM;
                ctrl.alu_ctrl   = ALU_ADD;
                ctrl.alu_out_ce = 1'b1;
                w_next_state    = (ctrl.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                ctrl.mem_rd = 1'b1;
                ctrl.i_or_d = 1'b1;
                ctrl.mdr_ce = ctrl.mem_ready;
                if (ctrl.mem_ready) begin
                    w_next_state = S_WB_MEM;
                end
            end
            S_MEM_WR: begin
                ctrl.mem_we = 1'b1;
                ctrl.i_or_d = 1'b1;
                if (ctrl.mem_ready) begin
                    w_next_state = S_IF;
                end
            end
            S_WB_MEM: begin
                ctrl.reg_we     = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                w_next_state    = S_IF;
            end
            S_BR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_ctrl  = ALU_SUB;
                ctrl.pc_src    = PCSRC_ALUOUT;
                ctrl.pc_ce     = ctrl.zero;
                w_next_state   = S_IF;
            end
            S_JMP: begin
                ctrl.pc_src  = PCSRC_JUMP;
                ctrl.pc_ce   = 1'b1;
                w_next_state = S_IF;
            end
            default: w_next_state = S_IF;
        endcase

        if (rst) begin
            ctrl.pc_ce      = 1'b0;
            ctrl.ir_ce      = 1'b0;
            ctrl.mdr_ce     = 1'b0;
            ctrl.ab_ce      = 1'b0;
            ctrl.alu_out_ce = 1'b0;
            ctrl.reg_we     = 1'b0;
            ctrl.mem_rd     = 1'b0;
            ctrl.mem_we     = 1'b0;
            ctrl.i_or_d     = 1'b0;
            ctrl.alu_src_a  = 1'b0;
            ctrl.alu_src_b  = SRCB_B;
            ctrl.alu_ctrl   = ALU_AND;
            ctrl.pc_src     = PCSRC_ALU;
            ctrl.reg_dst    = 1'b0;
            ctrl.mem_to_reg = 1'b0;
            ctrl.illegal    = 1'b0;
        end
    end

`ifdef MC_CTRL_PERF_CNT_EN
    logic [31:0] r_instr_cnt;
    logic        w_retire;

    // Illegal exits leave from ID/EX_R, which is_completing excludes.
    assign w_retire = (w_next_state == S_IF) && is_completing(r_state);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr_cnt <= '0;
        end else if (w_retire) begin
            r_instr_cnt <= r_instr_cnt + 32'd1;
        end
    end

    assign instr_cnt = rst ? 32'd0 : r_instr_cnt;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed-vector bench for mc_ctrl_fsm; outputs packed as {10 enables, alu_src_b, alu_ctrl, pc_src, reg_dst, mem_to_reg, illegal}.
// Counter checks are built when MC_CTRL_PERF_CNT_EN is defined.
module tb_mc_ctrl_fsm;

    logic clk;
    logic rst;
    int   nVectors;
    int   nMiscompares;

    mc_ctrl_fsm_if bus ();

`ifdef MC_CTRL_PERF_CNT_EN
    logic [31:0] instrCnt;
`endif

    mc_ctrl_fsm dut (
        .clk       (clk),
        .rst       (rst),
`ifdef MC_CTRL_PERF_CNT_EN
        .instr_cnt (instrCnt),
`endif
        .ctrl      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Enable order: pc, ir, mdr, ab, alu_out, reg_we, mem_rd, mem_we, i_or_d, alu_src_a.
    logic [19:0] obs;
    assign obs = {bus.pc_ce, bus.ir_ce, bus.mdr_ce, bus.ab_ce, bus.alu_out_ce,
                  bus.reg_we, bus.mem_rd, bus.mem_we, bus.i_or_d, bus.alu_src_a,
                  bus.alu_src_b, bus.alu_ctrl, bus.pc_src,
                  bus.reg_dst, bus.mem_to_reg, bus.illegal};

    localparam logic [19:0] V_IF_GO   = {10'b1100001000, 2'b01, 3'b010, 2'b00, 3'b000};
    localparam logic [19:0] V_IF_WAIT = {10'b0000001000, 2'b01, 3'b010, 2'b00, 3'b000};
    localparam logic [19:0] V_ID      = {10'b0001100000, 2'b11, 3'b010, 2'b00, 3'b000};
    localparam logic [19:0] V_ID_ILL  = {10'b0001100000, 2'b11, 3'b010, 2'b00, 3'b001};
    localparam logic [19:0] V_EXR_ADD = {10'b0000100001, 2'b00, 3'b010, 2'b00, 3'b000};
    localparam logic [19:0] V_EXR_ILL = {10'b0000100001, 2'b00, 3'b000, 2'b00, 3'b001};
    localparam logic [19:0] V_WB_R    = {10'b0000010000, 2'b00, 3'b000, 2'b00, 3'b100};
    localparam logic [19:0] V_ADDR    = {10'b0000100001, 2'b10, 3'b010, 2'b00, 3'b000};
    localparam logic [19:0] V_WB_I    = {10'b0000010000, 2'b00, 3'b000, 2'b00, 3'b000};
    localparam logic [19:0] V_RD_WAIT = {10'b0000001010, 2'b00, 3'b000, 2'b00, 3'b000};
    localparam logic [19:0] V_RD_GO   = {10'b0010001010, 2'b00, 3'b000, 2'b00, 3'b000};
    localparam logic [19:0] V_WB_MEM  = {10'b0000010000, 2'b00, 3'b000, 2'b00, 3'b010};
    localparam logic [19:0] V_WR      = {10'b0000000110, 2'b00, 3'b000, 2'b00, 3'b000};
    localparam logic [19:0] V_BR_TAKE = {10'b1000000001, 2'b00, 3'b110, 2'b01, 3'b000};
    localparam logic [19:0] V_BR_NOT  = {10'b0000000001, 2'b00, 3'b110, 2'b01, 3'b000};
    localparam logic [19:0] V_JMP     = {10'b1000000000, 2'b00, 3'b000, 2'b10, 3'b000};
    localparam logic [19:0] V_ZERO    = 20'h00000;

    task automatic step(input logic r, input logic mr, input logic z);
        @(negedge clk);
        rst           = r;
        bus.mem_ready = mr;
        bus.zero      = z;
        #1;
    endtask

    task automatic test_reset();
        logic [19:0] expv [3];
        logic        rv   [3];
        expv = '{V_ZERO, V_ZERO, V_IF_WAIT};
        rv   = '{1'b1, 1'b1, 1'b0};
        bus.opcode = 6'b000000;
        bus.funct  = 6'b100000;
        for (int i = 0; i < 3; i++) begin
            step(rv[i], rv[i], 1'b0);
            nVectors++;
            if (obs !== expv[i]) begin
                nMiscompares++;
                $display("[TB] FAIL reset[%0d]: observed %05h expected %05h", i, obs, expv[i]);
            end
        end
    endtask

    task automatic test_add();
        logic [19:0] expv [5];
        logic        mrv  [5];
        expv = '{V_IF_GO, V_ID, V_EXR_ADD, V_WB_R, V_IF_WAIT};
        mrv  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        bus.opcode = 6'b000000;
        bus.funct  = 6'b100000;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, mrv[i], 1'b0);
            nVectors++;
            if (obs !== expv[i]) begin
                nMiscompares++;
                $display("[TB] FAIL add[%0d]: observed %05h expected %05h", i, obs, expv[i]);
            end
        end
    endtask

    task automatic test_alu_funct();
        logic [5:0]  fn   [4];
        logic [2:0]  code [4];
        logic [19:0] expv [5];
        fn   = '{6'b100010, 6'b100100, 6'b100101, 6'b101010};
        code = '{3'b110, 3'b000, 3'b001, 3'b111};
        bus.opcode = 6'b000000;
        for (int k = 0; k < 4; k++) begin
            bus.funct = fn[k];
            expv = '{V_IF_GO, V_ID, {10'b0000100001, 2'b00, code[k], 2'b00, 3'b000}, V_WB_R, V_IF_WAIT};
            for (int i = 0; i < 5; i++) begin
                step(1'b0, (i == 0), 1'b0);
                nVectors++;
                if (obs !== expv[i]) begin
                    nMiscompares++;
                    $display("[TB] FAIL funct%0d[%0d]: observed %05h expected %05h", k, i, obs, expv[i]);
                end
            end
        end
    endtask

    task automatic test_addi();
        logic [19:0] expv [5];
        expv = '{V_IF_GO, V_ID, V_ADDR, V_WB_I, V_IF_WAIT};
        bus.opcode = 6'b001000;
        bus.funct  = 6'b000000;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, (i == 0), 1'b0);
            nVectors++;
            if (obs !== expv[i]) begin
                nMiscompares++;
                $display("[TB] FAIL addi[%0d]: observed %05h expected %05h", i, obs, expv[i]);
            end
        end
    endtask

    task automatic test_lw_wait();
        logic [19:0] expv [8];
        logic        mrv  [8];
        expv = '{V_IF_GO, V_ID, V_ADDR, V_RD_WAIT, V_RD_WAIT, V_RD_GO, V_WB_MEM, V_IF_WAIT};
        mrv  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        bus.opcode = 6'b100011;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, mrv[i], 1'b0);
            nVectors++;
            if (obs !== expv[i]) begin
                nMiscompares++;
                $display("[TB] FAIL lw[%0d]: observed %05h expected %05h", i, obs, expv[i]);
            end
        end
    endtask

    task automatic test_sw_wait();
        logic [19:0] expv [6];
        logic        mrv  [6];
        expv = '{V_IF_GO, V_ID, V_ADDR, V_WR, V_WR, V_IF_WAIT};
        mrv  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        bus.opcode = 6'b101011;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, mrv[i], 1'b0);
            nVectors++;
            if (obs !== expv[i]) begin
                nMiscompares++;
                $display("[TB] FAIL sw[%0d]: observed %05h expected %05h", i, obs, expv[i]);
            end
        end
    endtask

    task automatic test_beq();
        logic [19:0] expv [4];
        bus.opcode = 6'b000100;
        for (int k = 0; k < 2; k++) begin
            expv = '{V_IF_GO, V_ID, (k == 0) ? V_BR_TAKE : V_BR_NOT, V_IF_WAIT};
            for (int i = 0; i < 4; i++) begin
                step(1'b0, (i == 0), (k == 0));
                nVectors++;
                if (obs !== expv[i]) begin
                    nMiscompares++;
                    $display("[TB] FAIL beq_z%0d[%0d]: observed %05h expected %05h", 1 - k, i, obs, expv[i]);
                end
            end
        end
    endtask

    task automatic test_jmp();
        logic [19:0] expv [4];
        expv = '{V_IF_GO, V_ID, V_JMP, V_IF_WAIT};
        bus.opcode = 6'b000010;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, (i == 0), 1'b0);
            nVectors++;
            if (obs !== expv[i]) begin
                nMiscompares++;
                $display("[TB] FAIL jmp[%0d]: observed %05h expected %05h", i, obs, expv[i]);
            end
        end
    endtask

    task automatic test_illegal();
        logic [19:0] expOp [3];
        logic [19:0] expFn [4];
        expOp = '{V_IF_GO, V_ID_ILL, V_IF_WAIT};
        expFn = '{V_IF_GO, V_ID, V_EXR_ILL, V_IF_WAIT};
        bus.opcode = 6'b111111;
        bus.funct  = 6'b100000;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, (i == 0), 1'b0);
            nVectors++;
            if (obs !== expOp[i]) begin
                nMiscompares++;
                $display("[TB] FAIL ill_op[%0d]: observed %05h expected %05h", i, obs, expOp[i]);
            end
        end
        bus.opcode = 6'b000000;
        bus.funct  = 6'b000111;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, (i == 0), 1'b0);
            nVectors++;
            if (obs !== expFn[i]) begin
                nMiscompares++;
                $display("[TB] FAIL ill_fn[%0d]: observed %05h expected %05h", i, obs, expFn[i]);
            end
        end
    endtask

    task automatic test_sw_reset();
        logic [19:0] expv [6];
        logic        mrv  [6];
        logic        rv   [6];
        expv = '{V_IF_GO, V_ID, V_ADDR, V_WR, V_ZERO, V_IF_WAIT};
        mrv  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        rv   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        bus.opcode = 6'b101011;
        for (int i = 0; i < 6; i++) begin
            step(rv[i], mrv[i], 1'b0);
            nVectors++;
            if (obs !== expv[i]) begin
                nMiscompares++;
                $display("[TB] FAIL sw_rst[%0d]: observed %05h expected %05h", i, obs, expv[i]);
            end
        end
    endtask

`ifdef MC_CTRL_PERF_CNT_EN
    task automatic test_perf_cnt();
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        nVectors++;
        if (instrCnt !== 32'd0) begin
            nMiscompares++;
            $display("[TB] FAIL cnt_reset: observed %0d expected 0", instrCnt);
        end
        bus.opcode = 6'b000000;
        bus.funct  = 6'b100000;
        for (int i = 0; i < 5; i++) step(1'b0, (i == 0), 1'b0);
        nVectors++;
        if (instrCnt !== 32'd1) begin
            nMiscompares++;
            $display("[TB] FAIL cnt_add: observed %0d expected 1", instrCnt);
        end
        bus.opcode = 6'b111111;
        for (int i = 0; i < 3; i++) step(1'b0, (i == 0), 1'b0);
        nVectors++;
        if (instrCnt !== 32'd1) begin
            nMiscompares++;
            $display("[TB] FAIL cnt_illegal: observed %0d expected 1", instrCnt);
        end
    endtask
`endif

    initial begin
        nVectors      = 0;
        nMiscompares  = 0;
        rst           = 1'b1;
        bus.mem_ready = 1'b1;
        bus.zero      = 1'b0;
        bus.opcode    = 6'b000000;
        bus.funct     = 6'b000000;

        test_reset();
        test_add();
        test_alu_funct();
        test_addi();
        test_lw_wait();
        test_sw_wait();
        test_beq();
        test_jmp();
        test_illegal();
        test_sw_reset();
`ifdef MC_CTRL_PERF_CNT_EN
        test_perf_cnt();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
